// File: rtl/clic_ip_ctrl_if.sv
// Core acknowledge channel for the CLIC pending-bit controller.
// An ack transfers on a clock edge where ack_valid_i and ack_ready_o are both high.
interface clic_ip_ctrl_if #(
    parameter int SrcW = 5
) ();
    logic            ack_valid_i;
    logic [SrcW-1:0] ack_id_i;
    logic            ack_ready_o;
    logic            ack_err_o;

    modport master (
        output ack_valid_i,
        output ack_id_i,
        input  ack_ready_o,
        input  ack_err_o
    );

    modport slave (
        input  ack_valid_i,
        input  ack_id_i,
        output ack_ready_o,
        output ack_err_o
    );
endinterface

// File: rtl/clic_ip_ctrl.sv
// Per-source interrupt pending generation for the CLIC: synchronise, apply trigger mode,
// merge software writes and clear edge-triggered pending on core acknowledge.
module clic_ip_ctrl #(
    parameter int N_SOURCE    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int SrcW        = $clog2(N_SOURCE)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_SOURCE-1:0] intr_src_i,
    input  logic [N_SOURCE-1:0] le_i,
    input  logic [N_SOURCE-1:0] pol_i,
    input  logic [N_SOURCE-1:0] sw_we_i,
    input  logic [N_SOURCE-1:0] sw_wdata_i,
    clic_ip_ctrl_if.slave       ack_if,
    output logic [N_SOURCE-1:0] ip_o,
    output logic [N_SOURCE-1:0] ip_de_o,
    output logic                dbg_state_o
);

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_READY  = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic   ack_ready;

    logic [N_SOURCE-1:0] s;
    logic [N_SOURCE-1:0] prev_q;
    logic [N_SOURCE-1:0] pending_q, pending_d;
    logic [N_SOURCE-1:0] ip_de_q;
    logic                ack_err_q, ack_err_d;
    logic                ack_acc;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = intr_src_i;
    end else begin : g_sync
        logic [N_SOURCE-1:0] sync_q [SYNC_STAGES];
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            end else begin
                sync_q[0] <= intr_src_i;
                for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            end
        end
        assign s = sync_q[SYNC_STAGES-1];
    end

    // Acks are held off for one cycle after reset release.
    always_comb begin
        state_d   = state_q;
        ack_ready = 1'b0;
        case (state_q)
            ST_WARMUP: state_d   = ST_READY;
            ST_READY:  ack_ready = 1'b1;
            default:   state_d   = ST_WARMUP;
        endcase
    end

    assign ack_acc   = ack_if.ack_valid_i & ack_ready;
    assign ack_err_d = ack_acc & (int'(ack_if.ack_id_i) >= N_SOURCE);

    // Edge detection compares raw synchronised levels so a polarity flip alone is not an edge.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < N_SOURCE; i++) begin
            if (!le_i[i]) begin
                pending_d[i] = s[i] ^ pol_i[i];
            end else if ((s[i] != prev_q[i]) && (s[i] ^ pol_i[i])) begin
                pending_d[i] = 1'b1;
            end else if (ack_acc && (ack_if.ack_id_i == SrcW'(i))) begin
                pending_d[i] = 1'b0;
            end else if (sw_we_i[i]) begin
                pending_d[i] = sw_wdata_i[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_WARMUP;
            prev_q    <= '0;
            pending_q <= '0;
            ip_de_q   <= '0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= s;
            pending_q <= pending_d;
            ip_de_q   <= pending_d ^ pending_q;
            ack_err_q <= ack_err_d;
        end
    end

    assign ip_o               = pending_q;
    assign ip_de_o            = ip_de_q;
    assign ack_if.ack_ready_o = ack_ready;
    assign ack_if.ack_err_o   = ack_err_q;
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_clic_ip_ctrl.sv
// Randomised and directed checks of clic_ip_ctrl against a cycle-level behavioural model.
module tb_clic_ip_ctrl;
  localparam int N    = 24;
  localparam int SYNC = 2;
  localparam int SW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] intr, le, pol, we, wd;
  logic [N-1:0] ip, ip_de;
  logic dbg_state;

  clic_ip_ctrl_if #(.SrcW(SW)) ack_if ();

  clic_ip_ctrl #(.N_SOURCE(N), .SYNC_STAGES(SYNC)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .intr_src_i (intr),
    .le_i       (le),
    .pol_i      (pol),
    .sw_we_i    (we),
    .sw_wdata_i (wd),
    .ack_if     (ack_if.slave),
    .ip_o       (ip),
    .ip_de_o    (ip_de),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the synchroniser is a delay line of past input samples.
  logic [N-1:0] hist_q[$];
  logic [N-1:0] m_prev, m_pend, m_de;
  logic         m_err, m_ready;

  task automatic model_reset();
    hist_q.delete();
    for (int k = 0; k < SYNC; k++) hist_q.push_back('0);
    m_prev = '0; m_pend = '0; m_de = '0; m_err = 1'b0; m_ready = 1'b0;
  endtask

  task automatic model_tick();
    logic [N-1:0] s, np;
    logic acc;
    if (rst) begin
      model_reset();
      return;
    end
    s = hist_q[0];
    hist_q.pop_front();
    hist_q.push_back(intr);
    acc = ack_if.ack_valid_i && m_ready;
    np = m_pend;
    for (int i = 0; i < N; i++) begin
      logic act, evt;
      act = s[i] ^ pol[i];
      evt = (s[i] != m_prev[i]) && act;
      if (!le[i]) np[i] = act;
      else if (evt) np[i] = 1'b1;
      else if (acc && int'(ack_if.ack_id_i) == i) np[i] = 1'b0;
      else if (we[i]) np[i] = wd[i];
    end
    m_de   = np ^ m_pend;
    m_pend = np;
    m_prev = s;
    m_err  = acc && (int'(ack_if.ack_id_i) >= N);
    m_ready = 1'b1;
  endtask

  task automatic compare_all();
    chk("ip_o", ip, m_pend);
    chk("ip_de_o", ip_de, m_de);
    chk("ack_err_o", ack_if.ack_err_o, m_err);
    chk("ack_ready_o", ack_if.ack_ready_o, m_ready);
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    repeat (2) step();
    rst = 1'b0;
    #1;
    compare_all();
  endtask

  initial begin
    intr = '0; le = '0; pol = '0; we = '0; wd = '0;
    ack_if.ack_valid_i = 1'b0;
    ack_if.ack_id_i    = '0;
    model_reset();
    #1;
    chk("reset_ip", ip, 0);
    chk("reset_ready", ack_if.ack_ready_o, 0);
    repeat (2) step();
    rst = 1'b0;

    // Ack in the first cycle after release must not be accepted.
    ack_if.ack_valid_i = 1'b1;
    ack_if.ack_id_i    = 5'd30;
    #1;
    chk("t5_first_ready", ack_if.ack_ready_o, 0);
    step();
    ack_if.ack_valid_i = 1'b0;
    step();
    chk("t5_first_noerr", ack_if.ack_err_o, 0);

    // Rising edge on source 3 reaches ip_o after SYNC+1 cycles.
    le = '1;
    repeat (3) step();
    intr[3] = 1'b1;
    step(); chk("t1_lat1", ip[3], 0);
    step(); chk("t1_lat2", ip[3], 0);
    step(); chk("t1_set", ip[3], 1); chk("t1_de", ip_de[3], 1);
    step(); chk("t1_hold_de", ip_de[3], 0);

    // Ack clears; then an ack coinciding with a fresh edge leaves it pending.
    ack_if.ack_valid_i = 1'b1; ack_if.ack_id_i = 5'd3;
    step(); chk("t2_ack_clr", ip[3], 0);
    ack_if.ack_valid_i = 1'b0;
    intr[3] = 1'b0;
    repeat (3) step();
    intr[3] = 1'b1;
    repeat (3) step();
    chk("t2_reset_pend", ip[3], 1);
    intr[3] = 1'b0;
    repeat (3) step();
    intr[3] = 1'b1;
    repeat (2) step();
    ack_if.ack_valid_i = 1'b1; ack_if.ack_id_i = 5'd3;
    step(); chk("t2_race_ip", ip[3], 1); chk("t2_race_de", ip_de[3], 0);
    ack_if.ack_valid_i = 1'b0;

    // Level, active-low source 5; software writes ignored.
    le[5] = 1'b0; pol[5] = 1'b1; intr[5] = 1'b0;
    step(); chk("t3_low_active", ip[5], 1);
    intr[5] = 1'b1; we[5] = 1'b1; wd[5] = 1'b1;
    step();
    we[5] = 1'b0;
    repeat (2) step();
    chk("t3_inactive", ip[5], 0);

    // Edge source 7: software set/clear; polarity flip alone does nothing.
    we[7] = 1'b1; wd[7] = 1'b1;
    step(); chk("t4_sw_set", ip[7], 1);
    wd[7] = 1'b0;
    step(); chk("t4_sw_clr", ip[7], 0);
    we[7] = 1'b0; pol[7] = 1'b1;
    repeat (4) step();
    chk("t4_pol_only", ip[7], 0);

    // Out-of-range ack id.
    ack_if.ack_valid_i = 1'b1; ack_if.ack_id_i = 5'd30;
    step(); chk("t5_err", ack_if.ack_err_o, 1);
    ack_if.ack_valid_i = 1'b0;
    step(); chk("t5_err_pulse", ack_if.ack_err_o, 0);

    // Source 0 held high through reset.
    le[0] = 1'b1; pol[0] = 1'b0; intr[0] = 1'b1;
    repeat (4) step();
    do_reset();
    chk("t6_rst_ip", ip, 0);
    step(); chk("t6_lat1", ip[0], 0);
    step(); chk("t6_lat2", ip[0], 0);
    step(); chk("t6_set", ip[0], 1);

    // Randomised traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      intr = intr ^ (N'($urandom) & N'($urandom) & N'($urandom));
      we   = N'($urandom) & N'($urandom) & N'($urandom);
      wd   = N'($urandom);
      if ($urandom_range(0, 49) == 0) le  = N'($urandom);
      if ($urandom_range(0, 49) == 0) pol = pol ^ (N'($urandom) & N'($urandom));
      ack_if.ack_valid_i = ($urandom_range(0, 2) == 0);
      ack_if.ack_id_i    = SW'($urandom_range(0, 31));
      if ($urandom_range(0, 399) == 0) do_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
